// File: rtl/cpu_exec_stage.sv
// cpu_exec_stage: execute stage with a single-cycle ALU and a multi-cycle
// multiply, handshaked on both sides (valid/ready). Results, zero flag and
// branch target are registered and held until consumed downstream.
module cpu_exec_stage #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] pc_plus_one,
    input  logic [WIDTH-1:0] rdata1,
    input  logic [WIDTH-1:0] rdata2,
    input  logic [WIDTH-1:0] ext_imm,
    input  logic [5:0]       alu_op,
    input  logic             use_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_alu,
    output logic             out_zero,
    output logic [WIDTH-1:0] out_branch_target,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(MUL_CYCLES);

    localparam logic [5:0] OP_ADD = 6'd0;
    localparam logic [5:0] OP_SUB = 6'd1;
    localparam logic [5:0] OP_AND = 6'd2;
    localparam logic [5:0] OP_OR  = 6'd3;
    localparam logic [5:0] OP_XOR = 6'd4;
    localparam logic [5:0] OP_SLL = 6'd5;
    localparam logic [5:0] OP_SRL = 6'd6;
    localparam logic [5:0] OP_SLT = 6'd7;
    localparam logic [5:0] OP_MUL = 6'd8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_MUL
    } state_t;

    state_t            state_q, state_d;
    logic              ready_en_q, ready_en_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic [WIDTH-1:0]  br_pend_q, br_pend_d;
    logic [WIDTH-1:0]  alu_q, alu_d;
    logic              zero_q, zero_d;
    logic [WIDTH-1:0]  br_q, br_d;

    logic [WIDTH-1:0]  opnd_b;
    logic [WIDTH-1:0]  single_res;
    logic [WIDTH-1:0]  mul_res;
    logic [WIDTH-1:0]  br_sum;
    logic              accept;
    logic              is_mul;
    logic              mul_done;

    function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [5:0]       op);
        logic [SHW-1:0] sh;
        sh = b[SHW-1:0];
        case (op)
            OP_ADD:  alu_fn = a + b;
            OP_SUB:  alu_fn = a - b;
            OP_AND:  alu_fn = a & b;
            OP_OR:   alu_fn = a | b;
            OP_XOR:  alu_fn = a ^ b;
            OP_SLL:  alu_fn = a << sh;
            OP_SRL:  alu_fn = a >> sh;
            OP_SLT:  alu_fn = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_MUL:  alu_fn = a * b;
            default: alu_fn = '0;
        endcase
    endfunction

    assign opnd_b     = use_imm ? ext_imm : rdata2;
    assign single_res = alu_fn(rdata1, opnd_b, alu_op);
    assign mul_res    = alu_fn(op_a_q, op_b_q, OP_MUL);
    assign br_sum     = pc_plus_one + ext_imm;
    assign is_mul     = (alu_op == OP_MUL);
    assign accept     = in_valid && in_ready;
    assign mul_done   = (cnt_q == CW'(MUL_CYCLES - 1));

    // State and datapath registers; synchronous active-low reset clears everything
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ready_en_q <= 1'b0;
            cnt_q      <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            br_pend_q  <= '0;
            alu_q      <= '0;
            zero_q     <= 1'b0;
            br_q       <= '0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= ready_en_d;
            cnt_q      <= cnt_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            br_pend_q  <= br_pend_d;
            alu_q      <= alu_d;
            zero_q     <= zero_d;
            br_q       <= br_d;
        end
    end

    // Next-state logic: HOLD drains on out_ready and may refill in the same cycle
    always_comb begin
        state_d = state_q;
        // Registered so in_ready stays low through reset without a combinational path from rst
        ready_en_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = is_mul ? S_MUL : S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    if (accept) state_d = is_mul ? S_MUL : S_HOLD;
                    else        state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (mul_done) state_d = S_HOLD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state
    always_comb begin
        in_ready  = ready_en_q &&
                    ((state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready));
        out_valid = (state_q == S_HOLD);
        busy      = (state_q == S_MUL);
    end

    // Datapath updates: single-cycle results land directly, MUL operands are parked
    always_comb begin
        cnt_d     = cnt_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        br_pend_d = br_pend_q;
        alu_d     = alu_q;
        zero_d    = zero_q;
        br_d      = br_q;
        if (accept) begin
            if (is_mul) begin
                op_a_d    = rdata1;
                op_b_d    = opnd_b;
                br_pend_d = br_sum;
                cnt_d     = '0;
            end else begin
                alu_d  = single_res;
                zero_d = (single_res == '0);
                br_d   = br_sum;
            end
        end else if (state_q == S_MUL) begin
            if (mul_done) begin
                alu_d  = mul_res;
                zero_d = (mul_res == '0);
                br_d   = br_pend_q;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign out_alu           = alu_q;
    assign out_zero          = zero_q;
    assign out_branch_target = br_q;

endmodule

// File: tb/tb_cpu_exec_stage.sv
// Testbench for cpu_exec_stage: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_cpu_exec_stage;

    localparam int M = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc_plus_one, rdata1, rdata2, ext_imm;
    logic [5:0]  alu_op;
    logic        use_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_alu;
    logic        out_zero;
    logic [31:0] out_branch_target;
    logic        busy;

    int vectors;
    int miscompares;

    // reference model state
    logic        m_en, m_valid, m_zero;
    int          m_left;
    logic [31:0] m_alu, m_br, p_alu, p_br;
    logic        obs_rdy, exp_rdy;

    cpu_exec_stage #(.WIDTH(32), .MUL_CYCLES(M)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pc_plus_one(pc_plus_one), .rdata1(rdata1), .rdata2(rdata2),
        .ext_imm(ext_imm), .alu_op(alu_op), .use_imm(use_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu(out_alu),
        .out_zero(out_zero), .out_branch_target(out_branch_target), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [5:0] op);
        int sa, sb;
        logic [63:0] p;
        sa = a;
        sb = b;
        p  = 64'(a) * 64'(b);
        case (op)
            6'd0: return a + b;
            6'd1: return a - b;
            6'd2: return a & b;
            6'd3: return a | b;
            6'd4: return a ^ b;
            6'd5: return a << (b % 32);
            6'd6: return a >> (b % 32);
            6'd7: return (sa < sb) ? 32'd1 : 32'd0;
            6'd8: return p[31:0];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0: return 32'($urandom_range(0, 3));
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Drive one cycle of inputs, sample in_ready, clock, then advance the model.
    task automatic apply(input logic v, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                         input logic ui, input logic ordy);
        logic        acc;
        logic [31:0] r;
        in_valid = v; alu_op = op; rdata1 = a; rdata2 = b; ext_imm = imm;
        pc_plus_one = pc; use_imm = ui; out_ready = ordy;
        #1;
        obs_rdy = in_ready;
        exp_rdy = m_en && (m_left == 0) && (!m_valid || ordy);
        acc = v && exp_rdy;
        @(posedge clk);
        if (!rst) begin
            m_en = 1'b0; m_valid = 1'b0; m_left = 0;
            m_alu = '0; m_zero = 1'b0; m_br = '0;
        end else begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_valid = 1'b1; m_alu = p_alu; m_zero = (p_alu == 0); m_br = p_br;
                end
            end else begin
                if (m_valid && ordy) m_valid = 1'b0;
                if (acc) begin
                    r = ref_alu(a, ui ? imm : b, op);
                    if (op == 6'd8) begin
                        m_left = M; m_valid = 1'b0; p_alu = r; p_br = pc + imm;
                    end else begin
                        m_valid = 1'b1; m_alu = r; m_zero = (r == 0); m_br = pc + imm;
                    end
                end
            end
            m_en = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        apply(1'b0, 6'd0, '0, '0, '0, '0, 1'b0, ordy);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle(1'b1);
        idle(1'b1);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", out_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
        vectors++; if (out_alu !== 32'd0) begin miscompares++; $display("FAIL rst_alu got %h want 0", out_alu); end
        vectors++; if (out_zero !== 1'b0) begin miscompares++; $display("FAIL rst_zero got %b want 0", out_zero); end
        vectors++; if (out_branch_target !== 32'd0) begin miscompares++; $display("FAIL rst_br got %h want 0", out_branch_target); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready got %b want 0", in_ready); end
        rst = 1'b1;
        idle(1'b1);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rel_ready got %b want 1", in_ready); end
    endtask

    task automatic test_single_ops();
        apply(1'b1, 6'd0, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b1);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL add_valid got %b want 1", out_valid); end
        vectors++; if (out_alu !== 32'd12) begin miscompares++; $display("FAIL add_alu got %0d want 12", out_alu); end
        vectors++; if (out_zero !== 1'b0) begin miscompares++; $display("FAIL add_zero got %b want 0", out_zero); end
        apply(1'b1, 6'd1, 32'd9, 32'd3, 32'd9, 32'd100, 1'b1, 1'b1);
        vectors++; if (out_alu !== 32'd0) begin miscompares++; $display("FAIL sub_alu got %0d want 0", out_alu); end
        vectors++; if (out_zero !== 1'b1) begin miscompares++; $display("FAIL sub_zero got %b want 1", out_zero); end
        vectors++; if (out_branch_target !== 32'd109) begin miscompares++; $display("FAIL sub_br got %0d want 109", out_branch_target); end
        apply(1'b1, 6'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b1);
        vectors++; if (out_alu !== 32'd0 || out_zero !== 1'b1) begin miscompares++; $display("FAIL add_wrap got %h/%b want 0/1", out_alu, out_zero); end
        apply(1'b1, 6'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b1);
        vectors++; if (out_alu !== 32'd1) begin miscompares++; $display("FAIL slt_neg got %h want 1", out_alu); end
        apply(1'b1, 6'd6, 32'h8000_0000, 32'd31, 32'd0, 32'd0, 1'b0, 1'b1);
        vectors++; if (out_alu !== 32'd1) begin miscompares++; $display("FAIL srl_31 got %h want 1", out_alu); end
        apply(1'b1, 6'd63, 32'h1234_5678, 32'd5, 32'd0, 32'd0, 1'b0, 1'b1);
        vectors++; if (out_alu !== 32'd0 || out_zero !== 1'b1) begin miscompares++; $display("FAIL op63 got %h/%b want 0/1", out_alu, out_zero); end
        idle(1'b1);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_valid got %b want 0", out_valid); end
    endtask

    task automatic test_mul();
        apply(1'b1, 6'd8, 32'd6, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < M; i++) begin
            vectors++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                miscompares++; $display("FAIL mul_busy cyc %0d got busy=%b rdy=%b vld=%b want 1/0/0", i, busy, in_ready, out_valid); end
            idle(1'b0);
        end
        vectors++; if (out_valid !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL mul_done got vld=%b busy=%b want 1/0", out_valid, busy); end
        vectors++; if (out_alu !== 32'd42) begin miscompares++; $display("FAIL mul_alu got %0d want 42", out_alu); end
        idle(1'b1);
    endtask

    task automatic test_back_to_back();
        apply(1'b1, 6'd0, 32'd20, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 6'd0, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0);
            vectors++; if (obs_rdy !== 1'b0 || out_valid !== 1'b1 || out_alu !== 32'd23) begin
                miscompares++; $display("FAIL hold cyc %0d got rdy=%b vld=%b alu=%0d want 0/1/23", i, obs_rdy, out_valid, out_alu); end
        end
        for (int i = 1; i <= 4; i++) begin
            apply(1'b1, 6'd0, 32'(10 * i), 32'(i), 32'd0, 32'd0, 1'b0, 1'b1);
            vectors++; if (obs_rdy !== 1'b1 || out_valid !== 1'b1 || out_alu !== 32'(11 * i)) begin
                miscompares++; $display("FAIL stream %0d got rdy=%b vld=%b alu=%0d want 1/1/%0d", i, obs_rdy, out_valid, out_alu, 11 * i); end
        end
        idle(1'b1);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_end got %b want 0", out_valid); end
    endtask

    task automatic test_random();
        logic [5:0] op;
        for (int n = 0; n < 400; n++) begin
            op = 6'($urandom_range(0, 11));
            if ($urandom_range(0, 5) == 0) op = 6'd8;
            if ($urandom_range(0, 15) == 0) op = 6'd63;
            apply(1'($urandom_range(0, 3) != 0), op, rnd_word(), rnd_word(), rnd_word(),
                  $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
            vectors++; if (obs_rdy !== exp_rdy) begin miscompares++; $display("FAIL rnd_ready %0d got %b want %b", n, obs_rdy, exp_rdy); end
            vectors++; if (out_valid !== m_valid || busy !== (m_left > 0)) begin
                miscompares++; $display("FAIL rnd_status %0d got vld=%b busy=%b want %b/%b", n, out_valid, busy, m_valid, m_left > 0); end
            if (m_valid) begin
                vectors++; if (out_alu !== m_alu || out_zero !== m_zero || out_branch_target !== m_br) begin
                    miscompares++; $display("FAIL rnd_data %0d got %h/%b/%h want %h/%b/%h", n,
                        out_alu, out_zero, out_branch_target, m_alu, m_zero, m_br); end
            end
        end
        for (int i = 0; i < M + 2; i++) idle(1'b1);
    endtask

    task automatic test_reset_mid_mul();
        apply(1'b1, 6'd8, 32'd3, 32'd5, 32'd0, 32'd0, 1'b0, 1'b1);
        idle(1'b1);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_pre_busy got %b want 1", busy); end
        rst = 1'b0;
        idle(1'b1);
        vectors++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_alu !== 32'd0 || out_zero !== 1'b0 || out_branch_target !== 32'd0) begin
            miscompares++; $display("FAIL abort_clear got busy=%b vld=%b alu=%h z=%b br=%h want all 0",
                busy, out_valid, out_alu, out_zero, out_branch_target); end
        rst = 1'b1;
        for (int i = 0; i < M + 3; i++) begin
            idle(1'b1);
            vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++; $display("FAIL abort_after cyc %0d got vld=%b busy=%b want 0/0", i, out_valid, busy); end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        m_en = 1'b0; m_valid = 1'b0; m_left = 0; m_alu = '0; m_zero = 1'b0; m_br = '0;
        p_alu = '0; p_br = '0; obs_rdy = 1'b0; exp_rdy = 1'b0;
        rst = 1'b0; in_valid = 1'b0; alu_op = '0; rdata1 = '0; rdata2 = '0;
        ext_imm = '0; pc_plus_one = '0; use_imm = 1'b0; out_ready = 1'b0;
        test_reset();
        test_single_ops();
        test_mul();
        test_back_to_back();
        test_random();
        test_reset_mid_mul();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
